// File: rtl/seg_scan_driver_if.sv
// Score-display bus between the game controller and the seven-segment scan driver.
//   inp      : packed score word, nibble k shown on digit k (digit 0 rightmost)
//   flash    : 1 = blink the whole display
//   seg      : active-low segments, [6:0]=gfedcba, [7]=dp
//   anode    : active-low digit enables, anode[k] selects digit k
//   inactive : enables for the four unused digits of the 8-digit display
interface seg_scan_driver_if;
  logic [15:0] inp;
  logic        flash;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic [3:0]  inactive;

  modport master (output inp, flash, input seg, anode, inactive);
  modport slave  (input inp, flash, output seg, anode, inactive);
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the two players' scores.
// The score word is latched once per scan frame, so the display never tears.
// Zero tens digits can be blanked, and the whole display can blink.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : score word and flash in; seg/anode/inactive out (all registered)
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_driver_if.slave   bus
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_t;

  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [BLK_W-1:0] blink_cnt;
  phase_t           phase;

  logic             ref_wrap_c;
  logic             blink_wrap_c;
  logic [3:0]       nibble_c;
  logic             blank_c;
  logic             dark_c;

  // Active-low gfedcba pattern; 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Current slot's nibble, blanking and blink gating.
  always_comb begin
    nibble_c = 4'h0;
    case (idx)
      2'd0: nibble_c = shadow[3:0];
      2'd1: nibble_c = shadow[7:4];
      2'd2: nibble_c = shadow[11:8];
      2'd3: nibble_c = shadow[15:12];
      default: nibble_c = 4'h0;
    endcase
    ref_wrap_c   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
    blink_wrap_c = (blink_cnt == BLK_W'(BLINK_DIV - 1));
    blank_c      = BLANK_LZ && idx[0] && (nibble_c == 4'h0);
    // Dropping flash lights the display on the very next edge, not one later.
    dark_c       = (phase == PH_OFF) && bus.flash;
  end

  // Scan counters, frame latch, blink phase and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt      <= '0;
      idx          <= 2'd0;
      shadow       <= 16'h0000;
      blink_cnt    <= '0;
      phase        <= PH_ON;
      bus.seg      <= 8'hFF;
      bus.anode    <= 4'b1111;
      bus.inactive <= 4'b1111;
    end else begin
      ref_cnt <= ref_wrap_c ? '0 : ref_cnt + REF_W'(1);
      if (ref_wrap_c) begin
        idx <= idx + 2'd1;
        // Frame boundary: new score shows from the next digit-0 slot.
        if (idx == 2'd3) shadow <= bus.inp;
      end

      if (!bus.flash) begin
        blink_cnt <= '0;
        phase     <= PH_ON;
      end else if (blink_wrap_c) begin
        blink_cnt <= '0;
        phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end

      bus.inactive <= 4'b1111;
      if (dark_c) begin
        bus.anode <= 4'b1111;
        bus.seg   <= 8'hFF;
      end else begin
        bus.anode <= blank_c ? 4'b1111 : ~(4'b0001 << idx);
        // Decimal point separates the two players' scores.
        bus.seg   <= {(idx != 2'd2), decode(nibble_c)};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: one instance with zero-blanking, one without.
module tb_seg_scan_driver;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   edge_n;

  seg_scan_driver_if bus_a ();
  seg_scan_driver_if bus_b ();

  seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .BLANK_LZ(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .BLANK_LZ(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame for a score word: seg/anode per slot, slot 0 in the low bits.
  // seg holds the decoded pattern for every slot; an holds blanking-enabled anodes.
  typedef struct packed {
    logic [15:0] inp;
    logic [31:0] seg;
    logic [15:0] an;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %h want %h", name, edge_n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic set_in(input logic [15:0] v, input logic f);
    bus_a.inp   = v;
    bus_b.inp   = v;
    bus_a.flash = f;
    bus_b.flash = f;
  endtask

  task automatic check_reset_vals();
    chk("rst_anode_a", 8'(bus_a.anode), 8'h0F);
    chk("rst_seg_a", bus_a.seg, 8'hFF);
    chk("rst_inact_a", 8'(bus_a.inactive), 8'h0F);
    chk("rst_anode_b", 8'(bus_b.anode), 8'h0F);
    chk("rst_seg_b", bus_b.seg, 8'hFF);
  endtask

  task automatic check_norm(input vec_t v);
    int slot;
    logic [7:0] es;
    logic [3:0] ea;
    logic [3:0] eb;
    slot = ((edge_n - 1) / 4) % 4;
    es = v.seg[8*slot +: 8];
    ea = v.an[4*slot +: 4];
    eb = 4'b1111;
    eb[slot] = 1'b0;
    chk("anode_a", 8'(bus_a.anode), 8'(ea));
    if (ea != 4'b1111) chk("seg_a", bus_a.seg, es);
    chk("anode_b", 8'(bus_b.anode), 8'(eb));
    chk("seg_b", bus_b.seg, es);
    chk("inactive_a", 8'(bus_a.inactive), 8'h0F);
  endtask

  task automatic check_off();
    chk("off_anode_a", 8'(bus_a.anode), 8'h0F);
    chk("off_seg_a", bus_a.seg, 8'hFF);
    chk("off_anode_b", 8'(bus_b.anode), 8'h0F);
    chk("off_seg_b", bus_b.seg, 8'hFF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    vecs[0] = '{inp: 16'h0000, seg: 32'hC0_40_C0_C0, an: 16'hFBFE};
    vecs[1] = '{inp: 16'h1234, seg: 32'hF9_24_B0_99, an: 16'h7BDE};
    vecs[2] = '{inp: 16'h0509, seg: 32'hC0_12_C0_90, an: 16'hFBFE};
    vecs[3] = '{inp: 16'hA0F0, seg: 32'hBF_40_BF_C0, an: 16'h7BDE};
    vecs[4] = '{inp: 16'h5678, seg: 32'h92_02_F8_80, an: 16'h7BDE};
    vecs[5] = '{inp: 16'h9D0B, seg: 32'h90_3F_C0_BF, an: 16'h7BFE};
    vecs[6] = '{inp: 16'h0100, seg: 32'hC0_79_C0_C0, an: 16'hFBFE};

    reset = 1'b1;
    set_in(16'h0000, 1'b0);
    repeat (3) begin
      step();
      check_reset_vals();
    end

    // First edge after release shows digit 0 as '0'.
    reset  = 1'b0;
    edge_n = 0;
    step();
    chk("first_anode", 8'(bus_a.anode), 8'h0E);
    chk("first_seg", bus_a.seg, 8'hC0);
    repeat (15) begin
      step();
      check_norm(vecs[0]);
    end

    // Table: apply a word, let one frame pass, then check a whole frame.
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].inp, 1'b0);
      repeat (16) step();
      repeat (16) begin
        step();
        check_norm(vecs[i]);
      end
    end

    // Mid-frame input change must not tear the current frame.
    set_in(16'h1234, 1'b0);
    repeat (16) step();
    repeat (5) begin
      step();
      check_norm(vecs[1]);
    end
    set_in(16'h5678, 1'b0);
    repeat (11) begin
      step();
      check_norm(vecs[1]);
    end
    repeat (16) begin
      step();
      check_norm(vecs[4]);
    end

    // Blink: 16 on, 16 off, 16 on, then drop flash inside an off phase.
    set_in(16'h5678, 1'b1);
    repeat (16) begin
      step();
      check_norm(vecs[4]);
    end
    repeat (16) begin
      step();
      check_off();
    end
    repeat (16) begin
      step();
      check_norm(vecs[4]);
    end
    repeat (5) begin
      step();
      check_off();
    end
    set_in(16'h5678, 1'b0);
    repeat (11) begin
      step();
      check_norm(vecs[4]);
    end

    // Reset in the middle of a dark blink phase restores the post-reset state.
    set_in(16'h5678, 1'b1);
    repeat (20) step();
    reset = 1'b1;
    repeat (3) begin
      step();
      check_reset_vals();
    end
    reset  = 1'b0;
    edge_n = 0;
    step();
    chk("rerst_anode", 8'(bus_a.anode), 8'h0E);
    chk("rerst_seg", bus_a.seg, 8'hC0);
    repeat (15) begin
      step();
      check_norm(vecs[0]);
    end
    step();
    check_off();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
